// File: rtl/bist_sig_analyzer.sv
// BIST signature analyzer: MISR compaction of circuit-under-test responses,
// session sequencing and a registered pass/fail/length verdict against GOLDEN.
module bist_sig_analyzer #(
  parameter int unsigned          WIDTH  = 16,
  parameter logic [WIDTH-1:0]     POLY   = 16'h1021,
  parameter logic [WIDTH-1:0]     SEED   = 16'h0000,
  parameter logic [WIDTH-1:0]     GOLDEN = 16'h0400,
  parameter int unsigned          NRUN   = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             finish,
  input  logic [WIDTH-1:0] cut_out,
  output logic [WIDTH-1:0] signature,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             len_err
);

  localparam int unsigned CW = $clog2(NRUN + 1) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    COMPACT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [WIDTH-1:0]  sig_r, sig_s, upd_sig_s;
  logic [CW-1:0]     cnt_r, cnt_s, upd_cnt_s;
  logic              done_r, done_s;
  logic              pass_r, pass_s;
  logic              fail_r, fail_s;
  logic              len_err_r, len_err_s;
  logic              len_bad_s;

  // One MISR step: shift left, fold the polynomial back in on carry-out, absorb the response word.
  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] sig,
                                                  input logic [WIDTH-1:0] din);
    misr_step = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : {WIDTH{1'b0}}) ^ din;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; init wins over running/finish in every state.
  always_comb begin
    state_s = state_r;
    if (init) begin
      state_s = ARMED;
    end else begin
      case (state_r)
        ARMED: begin
          if (finish) begin
            state_s = DONE;
          end else if (running) begin
            state_s = COMPACT;
          end else begin
            state_s = ARMED;
          end
        end
        COMPACT: begin
          if (finish) begin
            state_s = DONE;
          end else begin
            state_s = COMPACT;
          end
        end
        DONE:    state_s = DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Output/datapath next values; the verdict uses the same-cycle compaction result.
  always_comb begin
    sig_s     = sig_r;
    cnt_s     = cnt_r;
    done_s    = done_r;
    pass_s    = pass_r;
    fail_s    = fail_r;
    len_err_s = len_err_r;
    upd_sig_s = sig_r;
    upd_cnt_s = cnt_r;
    len_bad_s = 1'b0;
    if (init) begin
      sig_s     = SEED;
      cnt_s     = {CW{1'b0}};
      done_s    = 1'b0;
      pass_s    = 1'b0;
      fail_s    = 1'b0;
      len_err_s = 1'b0;
    end else begin
      case (state_r)
        ARMED, COMPACT: begin
          if (running) begin
            upd_sig_s = misr_step(sig_r, cut_out);
            upd_cnt_s = (cnt_r == {CW{1'b1}}) ? cnt_r : cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            upd_sig_s = sig_r;
            upd_cnt_s = cnt_r;
          end
          sig_s = upd_sig_s;
          cnt_s = upd_cnt_s;
          if (finish) begin
            len_bad_s = (upd_cnt_s != CW'(NRUN));
            done_s    = 1'b1;
            len_err_s = len_bad_s;
            pass_s    = (upd_sig_s == GOLDEN) && !len_bad_s;
            fail_s    = !((upd_sig_s == GOLDEN) && !len_bad_s);
          end else begin
            done_s = done_r;
          end
        end
        default: begin
          sig_s = sig_r;
        end
      endcase
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_r     <= SEED;
      cnt_r     <= {CW{1'b0}};
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      fail_r    <= 1'b0;
      len_err_r <= 1'b0;
    end else begin
      sig_r     <= sig_s;
      cnt_r     <= cnt_s;
      done_r    <= done_s;
      pass_r    <= pass_s;
      fail_r    <= fail_s;
      len_err_r <= len_err_s;
    end
  end

  assign signature = sig_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign fail      = fail_r;
  assign len_err   = len_err_r;

endmodule
